// File: rtl/debug_led_pkg.sv
// Shared mode encodings for the 7-segment LED debug mirror.
// Optional heartbeat on LD[SEG_W] is enabled by defining DEBUG_LED_HEARTBEAT_EN.
package debug_led_pkg;

   typedef enum logic [1:0] {
      MODE_MANUAL = 2'b00,
      MODE_SCAN   = 2'b01,
      MODE_FREEZE = 2'b10
   } mode_t;

   // The unused encoding 2'b11 behaves exactly like MANUAL.
   function automatic mode_t norm_mode(input logic [1:0] m);
      case (m)
         2'b01:   norm_mode = MODE_SCAN;
         2'b10:   norm_mode = MODE_FREEZE;
         default: norm_mode = MODE_MANUAL;
      endcase
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// Free-running dwell counter 0..DWELL_CYCLES-1; tick marks the last count.
// A tick or clr returns the count to zero on the next edge.
module dwell_timer #(
   parameter int DWELL_CYCLES = 50_000_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(DWELL_CYCLES - 1);

   logic [CW-1:0] cnt;

   assign tick = (cnt == LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clr || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/debug_seg_scan_led.sv
// Mirrors one digit of an active-low 7-segment bus onto LEDs (manual / scan / freeze).
// Define DEBUG_LED_HEARTBEAT_EN to turn LD[SEG_W] into a dwell-rate heartbeat.
module debug_seg_scan_led
   import debug_led_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int SEG_W        = 7,
   parameter int DWELL_CYCLES = 50_000_000,
   localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_DIGITS*SEG_W-1:0] seg_n,
   input  logic [1:0]                  mode,
   input  logic                        step,
   output logic [SEG_W:0]              LD,
   output logic [IDX_W-1:0]            digit_idx,
   output logic                        idx_adv
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   mode_t            mode_n;
   mode_t            mode_q;
   logic             mode_chg;
   logic             tick_raw;
   logic             tick;
   logic             adv;
   logic [IDX_W-1:0] idx_inc;
   logic [IDX_W-1:0] idx_next;
   logic [SEG_W-1:0] live_sel;
   logic [SEG_W-1:0] snapshot;
   logic [SEG_W-1:0] ld_seg;

   assign mode_n   = norm_mode(mode);
   assign mode_chg = (mode_n != mode_q);

   // A step in SCAN restarts the dwell but must not swallow a coincident tick.
   dwell_timer #(
      .DWELL_CYCLES(DWELL_CYCLES)
   ) u_dwell (
      .clk  (clk),
      .rst_n(rst_n),
      .clr  (mode_chg || ((mode_n == MODE_SCAN) && step)),
      .tick (tick_raw)
   );

   assign tick = tick_raw && !mode_chg;

   always_comb begin
      adv = 1'b0;
      case (mode_n)
         MODE_MANUAL: adv = step;
         MODE_SCAN:   adv = step || tick;
         default:     adv = 1'b0;
      endcase
   end

   assign idx_inc  = (digit_idx == LAST_IDX) ? '0 : digit_idx + 1'b1;
   assign idx_next = adv ? idx_inc : digit_idx;
   assign live_sel = ~seg_n[idx_next*SEG_W +: SEG_W];

   // mode_q is the controller state; the freeze entry cycle captures and shows the digit at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_q    <= MODE_MANUAL;
         digit_idx <= '0;
         idx_adv   <= 1'b0;
         snapshot  <= '0;
         ld_seg    <= '0;
      end else begin
         mode_q    <= mode_n;
         digit_idx <= idx_next;
         idx_adv   <= adv && (NUM_DIGITS > 1);
         if (mode_n == MODE_FREEZE) begin
            if (mode_q != MODE_FREEZE) begin
               snapshot <= live_sel;
               ld_seg   <= live_sel;
            end else begin
               ld_seg   <= snapshot;
            end
         end else begin
            ld_seg <= live_sel;
         end
      end
   end

`ifdef DEBUG_LED_HEARTBEAT_EN
   logic heartbeat;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         heartbeat <= 1'b0;
      end else if (tick) begin
         heartbeat <= ~heartbeat;
      end
   end

   assign LD = {heartbeat, ld_seg};
`else
   assign LD = {1'b1, ld_seg};
`endif

endmodule

// File: tb/tb_debug_seg_scan_led.sv
// Directed bench for debug_seg_scan_led with NUM_DIGITS=4, SEG_W=7, DWELL_CYCLES=4.
// Checks are taken 1 time unit after the rising edge; inputs change at the same point.
module tb_debug_seg_scan_led;

   localparam int ND = 4;
   localparam int SW = 7;
   localparam int DW = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [ND*SW-1:0] seg_n;
   logic [1:0]    mode;
   logic          step;
   logic [SW:0]   LD;
   logic [1:0]    digit_idx;
   logic          idx_adv;

   int            n_cmp = 0;
   int            n_bad = 0;
   logic [6:0]    pat [4];

   always #5 clk = ~clk;

   debug_seg_scan_led #(
      .NUM_DIGITS  (ND),
      .SEG_W       (SW),
      .DWELL_CYCLES(DW)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .seg_n    (seg_n),
      .mode     (mode),
      .step     (step),
      .LD       (LD),
      .digit_idx(digit_idx),
      .idx_adv  (idx_adv)
   );

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [1:0] ei, input logic [6:0] el, input logic ea);
      n_cmp++;
      assert (digit_idx === ei) else begin
         n_bad++;
         $error("FAIL %s digit_idx observed %0d expected %0d", tag, digit_idx, ei);
      end
      n_cmp++;
      assert (LD[6:0] === el) else begin
         n_bad++;
         $error("FAIL %s LD[6:0] observed %h expected %h", tag, LD[6:0], el);
      end
      n_cmp++;
      assert (idx_adv === ea) else begin
         n_bad++;
         $error("FAIL %s idx_adv observed %b expected %b", tag, idx_adv, ea);
      end
`ifndef DEBUG_LED_HEARTBEAT_EN
      n_cmp++;
      assert (LD[7] === 1'b1) else begin
         n_bad++;
         $error("FAIL %s LD[7] observed %b expected 1", tag, LD[7]);
      end
`endif
   endtask

   // Three quiet cycles holding prev, then the tick advance to nxt (DWELL_CYCLES=4).
   task automatic scan_adv(input string tag, input logic [1:0] prv, input logic [1:0] nxt);
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk(tag, prv, pat[prv], 1'b0);
      end
      cyc(1);
      chk(tag, nxt, pat[nxt], 1'b1);
   endtask

`ifdef DEBUG_LED_HEARTBEAT_EN
   task automatic hb_chk(input string tag, input logic eh);
      n_cmp++;
      assert (LD[7] === eh) else begin
         n_bad++;
         $error("FAIL %s LD[7] observed %b expected %b", tag, LD[7], eh);
      end
   endtask
`endif

   initial begin
      pat[0] = 7'h3F;
      pat[1] = 7'h06;
      pat[2] = 7'h5B;
      pat[3] = 7'h4F;
      seg_n  = {7'h30, 7'h24, 7'h79, 7'h40};
      mode   = 2'b00;
      step   = 1'b0;
      rst_n  = 1'b0;

      cyc(2);
      n_cmp++;
      assert (LD[6:0] === 7'h00 && digit_idx === 2'd0 && idx_adv === 1'b0) else begin
         n_bad++;
         $error("FAIL in_reset LD=%h idx=%0d adv=%b expected 00/0/0", LD[6:0], digit_idx, idx_adv);
      end
      rst_n = 1'b1;
      cyc(1);
      chk("after_reset", 2'd0, 7'h3F, 1'b0);

      // MANUAL stepping with wrap; dwell ticks in between must not move the index.
      for (int k = 0; k < 5; k++) begin
         step = 1'b1;
         cyc(1);
         step = 1'b0;
         chk("man_step", 2'((k + 1) % 4), pat[(k + 1) % 4], 1'b1);
         cyc(1);
         chk("man_gap", 2'((k + 1) % 4), pat[(k + 1) % 4], 1'b0);
      end
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk("man_idle", 2'd1, pat[1], 1'b0);
      end

      // SCAN: entry edge restarts the dwell, then one advance every 4 cycles.
      mode = 2'b01;
      cyc(1);
      chk("scan_entry", 2'd1, pat[1], 1'b0);
      scan_adv("scan_a", 2'd1, 2'd2);
      scan_adv("scan_b", 2'd2, 2'd3);
      scan_adv("scan_wrap", 2'd3, 2'd0);
      scan_adv("scan_c", 2'd0, 2'd1);

      // step lands on the tick cycle: a single advance, dwell restarts.
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("pre_tick_step", 2'd1, pat[1], 1'b0);
      end
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      chk("tick_step", 2'd2, pat[2], 1'b1);
      scan_adv("after_tick_step", 2'd2, 2'd3);
      scan_adv("scan_d", 2'd3, 2'd0);
      scan_adv("scan_e", 2'd0, 2'd1);
      scan_adv("scan_f", 2'd1, 2'd2);

      // FREEZE at idx 2: snapshot held although seg_n changes and step pulses.
      mode = 2'b10;
      cyc(1);
      chk("frz_entry", 2'd2, 7'h5B, 1'b0);
      seg_n = '0;
      step  = 1'b1;
      cyc(1);
      step  = 1'b0;
      chk("frz_step", 2'd2, 7'h5B, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         chk("frz_hold", 2'd2, 7'h5B, 1'b0);
      end

      // Back to SCAN: live digit (now ~0 = 7F) one cycle later, dwell restarted.
      mode = 2'b01;
      cyc(1);
      chk("scan_resume", 2'd2, 7'h7F, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("resume_quiet", 2'd2, 7'h7F, 1'b0);
      end
      cyc(1);
      chk("resume_adv", 2'd3, 7'h7F, 1'b1);

      // Asynchronous reset mid-cycle at idx 3.
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst", 2'd0, 7'h00, 1'b0);
      cyc(1);
      chk("rst_held", 2'd0, 7'h00, 1'b0);
      rst_n = 1'b1;
      // mode_q leaves reset as MANUAL, so the first edge is the SCAN entry that starts the dwell.
      cyc(1);
      chk("rel_entry", 2'd0, 7'h7F, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk("rel_quiet", 2'd0, 7'h7F, 1'b0);
      end
      cyc(1);
      chk("rel_first_adv", 2'd1, 7'h7F, 1'b1);

      // mode 11 acts as MANUAL: a step advances, ticks do not.
      mode = 2'b11;
      cyc(1);
      chk("m11_entry", 2'd1, 7'h7F, 1'b0);
      step = 1'b1;
      cyc(1);
      step = 1'b0;
      chk("m11_step", 2'd2, 7'h7F, 1'b1);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk("m11_idle", 2'd2, 7'h7F, 1'b0);
      end

`ifdef DEBUG_LED_HEARTBEAT_EN
      // Heartbeat: toggles on each tick from 0, including while frozen.
      rst_n = 1'b0;
      mode  = 2'b00;
      #1;
      hb_chk("hb_reset", 1'b0);
      cyc(1);
      rst_n = 1'b1;
      cyc(3);
      hb_chk("hb_pre1", 1'b0);
      cyc(1);
      hb_chk("hb_t1", 1'b1);
      mode = 2'b10;
      cyc(4);
      hb_chk("hb_frz_pre", 1'b1);
      cyc(1);
      hb_chk("hb_frz_t2", 1'b0);
      cyc(3);
      hb_chk("hb_frz_pre3", 1'b0);
      cyc(1);
      hb_chk("hb_frz_t3", 1'b1);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
